// File: rtl/neuron_param_loader_if.sv
// Stream-in / committed-parameters-out bundle between the config source and the neuron.
// The slave modport is the loader's side; the master modport drives bytes and observes results.
interface neuron_param_loader_if;
    logic [7:0] data_in;
    logic       data_valid;
    logic [7:0] external_input_current;
    logic [7:0] threshold;
    logic [7:0] leak;
    logic [5:0] refractory_period;
    logic [7:0] scale_factor;
    logic       feedback_delay;
    logic       params_valid;
    logic       busy;
    logic       config_done;
    logic       config_error;

    modport slave (
        input  data_in,
        input  data_valid,
        output external_input_current,
        output threshold,
        output leak,
        output refractory_period,
        output scale_factor,
        output feedback_delay,
        output params_valid,
        output busy,
        output config_done,
        output config_error
    );

    modport master (
        output data_in,
        output data_valid,
        input  external_input_current,
        input  threshold,
        input  leak,
        input  refractory_period,
        input  scale_factor,
        input  feedback_delay,
        input  params_valid,
        input  busy,
        input  config_done,
        input  config_error
    );
endinterface

// File: rtl/neuron_param_loader.sv
// Deserialises SYNC,P0..P5,CHK frames into a shadow bank and commits it atomically on a good XOR checksum.
// Latency: parameters and config_done appear the cycle after CHK is accepted; no backpressure, bytes taken whenever data_valid=1.
module neuron_param_loader #(
    parameter logic [7:0] SYNC_BYTE     = 8'hA5,
    parameter int         TIMEOUT       = 255,
    parameter logic [7:0] RST_THRESHOLD = 8'd128,
    parameter logic [7:0] RST_LEAK      = 8'd1,
    parameter logic [5:0] RST_REFRAC    = 6'd4,
    parameter logic [7:0] RST_SCALE     = 8'd1
) (
    input  logic                  clk,
    input  logic                  reset,
    neuron_param_loader_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] xor_q, xor_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] shadow_q [6];
    logic [7:0] shadow_d [6];

    logic [7:0] cur_q, cur_d;
    logic [7:0] thr_q, thr_d;
    logic [7:0] leak_q, leak_d;
    logic [5:0] refrac_q, refrac_d;
    logic [7:0] scale_q, scale_d;
    logic       fbd_q, fbd_d;
    logic       pvld_q, pvld_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= 3'd0;
            xor_q    <= 8'd0;
            cnt_q    <= 8'd0;
            for (int i = 0; i < 6; i++) shadow_q[i] <= 8'd0;
            cur_q    <= 8'd0;
            thr_q    <= RST_THRESHOLD;
            leak_q   <= RST_LEAK;
            refrac_q <= RST_REFRAC;
            scale_q  <= RST_SCALE;
            fbd_q    <= 1'b0;
            pvld_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            xor_q    <= xor_d;
            cnt_q    <= cnt_d;
            for (int i = 0; i < 6; i++) shadow_q[i] <= shadow_d[i];
            cur_q    <= cur_d;
            thr_q    <= thr_d;
            leak_q   <= leak_d;
            refrac_q <= refrac_d;
            scale_q  <= scale_d;
            fbd_q    <= fbd_d;
            pvld_q   <= pvld_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        xor_d    = xor_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < 6; i++) shadow_d[i] = shadow_q[i];
        cur_d    = cur_q;
        thr_d    = thr_q;
        leak_d   = leak_q;
        refrac_d = refrac_q;
        scale_d  = scale_q;
        fbd_d    = fbd_q;
        pvld_d   = pvld_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = 8'd0;
                if (bus.data_valid && (bus.data_in == SYNC_BYTE)) begin
                    state_d = ST_LOAD;
                    idx_d   = 3'd0;
                    xor_d   = 8'd0;
                end
            end
            ST_LOAD: begin
                if (bus.data_valid) begin
                    // A SYNC value here is ordinary payload; there is no resync.
                    shadow_d[idx_q] = bus.data_in;
                    xor_d           = xor_q ^ bus.data_in;
                    cnt_d           = 8'd0;
                    if (idx_q == 3'd5) begin
                        state_d = ST_CHECK;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_CHECK: begin
                if (bus.data_valid) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                    if (bus.data_in == xor_q) begin
                        cur_d    = shadow_q[0];
                        thr_d    = shadow_q[1];
                        leak_d   = shadow_q[2];
                        refrac_d = shadow_q[3][5:0];
                        scale_d  = shadow_q[4];
                        fbd_d    = shadow_q[5][0];
                        pvld_d   = 1'b1;
                        done_d   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // busy comes straight from the state register, so it rises the cycle after SYNC.
    assign bus.busy                   = (state_q != ST_IDLE);
    assign bus.external_input_current = cur_q;
    assign bus.threshold              = thr_q;
    assign bus.leak                   = leak_q;
    assign bus.refractory_period      = refrac_q;
    assign bus.scale_factor           = scale_q;
    assign bus.feedback_delay         = fbd_q;
    assign bus.params_valid           = pvld_q;
    assign bus.config_done            = done_q;
    assign bus.config_error           = err_q;

endmodule

// File: tb/tb_neuron_param_loader.sv
// Directed bench for neuron_param_loader: frames, checksum errors, timeout, resync-free load and async reset.
module tb_neuron_param_loader;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   busy_cnt;
    int   done_cnt;
    int   err_cnt;

    neuron_param_loader_if bus ();

    neuron_param_loader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_counts();
        busy_cnt = 0;
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    // Sample at the falling edge (outputs of the previous rising edge), then drive the next input.
    task automatic step(input logic v, input logic [7:0] b);
        @(negedge clk);
        busy_cnt += int'(bus.busy);
        done_cnt += int'(bus.config_done);
        err_cnt  += int'(bus.config_error);
        bus.data_valid = v;
        bus.data_in    = b;
    endtask

    task automatic send_frame(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                              input logic [7:0] p3, input logic [7:0] p4, input logic [7:0] p5,
                              input logic [7:0] chk);
        step(1'b1, 8'hA5);
        step(1'b1, p0);
        step(1'b1, p1);
        step(1'b1, p2);
        step(1'b1, p3);
        step(1'b1, p4);
        step(1'b1, p5);
        step(1'b1, chk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.data_valid = 1'b0;
        bus.data_in    = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.threshold, bus.leak, bus.refractory_period, bus.scale_factor} !== {8'd128, 8'd1, 6'd4, 8'd1}) begin
            failures++;
            $display("FAIL reset_params got thr=%0d leak=%0d ref=%0d scale=%0d want 128 1 4 1",
                     bus.threshold, bus.leak, bus.refractory_period, bus.scale_factor);
        end
        checks++;
        if ({bus.external_input_current, bus.feedback_delay, bus.params_valid, bus.busy,
             bus.config_done, bus.config_error} !== {8'd0, 5'b00000}) begin
            failures++;
            $display("FAIL reset_flags got cur=%0d fbd=%b pv=%b busy=%b done=%b err=%b want all 0",
                     bus.external_input_current, bus.feedback_delay, bus.params_valid, bus.busy,
                     bus.config_done, bus.config_error);
        end
    endtask

    task automatic test_bad_checksum();
        clear_counts();
        send_frame(8'h10, 8'h40, 8'h02, 8'h05, 8'h03, 8'h01, 8'h54);
        repeat (4) step(1'b0, 8'h00);
        checks++;
        if (err_cnt !== 1 || done_cnt !== 0) begin
            failures++;
            $display("FAIL bad_chk_pulses got err=%0d done=%0d want err=1 done=0", err_cnt, done_cnt);
        end
        checks++;
        if ({bus.threshold, bus.external_input_current, bus.params_valid} !== {8'd128, 8'd0, 1'b0}) begin
            failures++;
            $display("FAIL bad_chk_outputs got thr=%0d cur=%0d pv=%b want 128 0 0",
                     bus.threshold, bus.external_input_current, bus.params_valid);
        end
    endtask

    task automatic test_good_frame();
        clear_counts();
        send_frame(8'h10, 8'h40, 8'h02, 8'h05, 8'h03, 8'h01, 8'h55);
        step(1'b0, 8'h00);
        checks++;
        if (done_cnt !== 1) begin
            failures++;
            $display("FAIL good_done_next_cycle got done_cnt=%0d want 1", done_cnt);
        end
        checks++;
        if ({bus.external_input_current, bus.threshold, bus.leak, bus.refractory_period,
             bus.scale_factor, bus.feedback_delay, bus.params_valid} !==
            {8'h10, 8'h40, 8'h02, 6'd5, 8'h03, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL good_params got cur=%h thr=%h leak=%h ref=%0d scale=%h fbd=%b pv=%b want 10 40 02 5 03 1 1",
                     bus.external_input_current, bus.threshold, bus.leak, bus.refractory_period,
                     bus.scale_factor, bus.feedback_delay, bus.params_valid);
        end
        repeat (3) step(1'b0, 8'h00);
        checks++;
        if (busy_cnt !== 7 || done_cnt !== 1 || err_cnt !== 0) begin
            failures++;
            $display("FAIL good_busy_pulse got busy=%0d done=%0d err=%0d want 7 1 0", busy_cnt, done_cnt, err_cnt);
        end
    endtask

    task automatic test_timeout();
        clear_counts();
        step(1'b1, 8'hA5);
        step(1'b1, 8'h10);
        step(1'b1, 8'h40);
        repeat (200) step(1'b0, 8'h00);
        checks++;
        if (bus.busy !== 1'b1 || err_cnt !== 0) begin
            failures++;
            $display("FAIL timeout_early got busy=%b err=%0d want busy=1 err=0", bus.busy, err_cnt);
        end
        repeat (100) step(1'b0, 8'h00);
        checks++;
        if (err_cnt !== 1 || done_cnt !== 0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_abort got err=%0d done=%0d busy=%b want 1 0 0", err_cnt, done_cnt, bus.busy);
        end
        checks++;
        if ({bus.external_input_current, bus.threshold} !== {8'h10, 8'h40}) begin
            failures++;
            $display("FAIL timeout_keep got cur=%h thr=%h want 10 40", bus.external_input_current, bus.threshold);
        end
        clear_counts();
        send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07);
        repeat (3) step(1'b0, 8'h00);
        checks++;
        if ({bus.external_input_current, bus.threshold, bus.leak, bus.refractory_period,
             bus.scale_factor, bus.feedback_delay} !== {8'h01, 8'h02, 8'h03, 6'd4, 8'h05, 1'b0}
            || done_cnt !== 1) begin
            failures++;
            $display("FAIL after_timeout_commit got cur=%h thr=%h leak=%h ref=%0d scale=%h fbd=%b done=%0d want 01 02 03 4 05 0 1",
                     bus.external_input_current, bus.threshold, bus.leak, bus.refractory_period,
                     bus.scale_factor, bus.feedback_delay, done_cnt);
        end
    endtask

    task automatic test_ignore_leading();
        clear_counts();
        step(1'b1, 8'h00);
        step(1'b1, 8'hFF);
        step(1'b1, 8'hA4);
        step(1'b0, 8'h00);
        checks++;
        if (bus.busy !== 1'b0 || err_cnt !== 0) begin
            failures++;
            $display("FAIL idle_junk got busy=%b err=%0d want 0 0", bus.busy, err_cnt);
        end
        send_frame(8'h10, 8'h40, 8'h02, 8'hC5, 8'h03, 8'h01, 8'h95);
        repeat (3) step(1'b0, 8'h00);
        checks++;
        if (bus.refractory_period !== 6'd5 || done_cnt !== 1 || err_cnt !== 0 || bus.feedback_delay !== 1'b1) begin
            failures++;
            $display("FAIL masked_refrac got ref=%0d fbd=%b done=%0d err=%0d want 5 1 1 0",
                     bus.refractory_period, bus.feedback_delay, done_cnt, err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        clear_counts();
        send_frame(8'h10, 8'h40, 8'h02, 8'h05, 8'h03, 8'h01, 8'h55);
        send_frame(8'hA5, 8'h11, 8'h22, 8'h3F, 8'h44, 8'h00, 8'hED);
        step(1'b0, 8'h00);
        checks++;
        if ({bus.external_input_current, bus.threshold, bus.leak, bus.refractory_period,
             bus.scale_factor, bus.feedback_delay} !== {8'hA5, 8'h11, 8'h22, 6'h3F, 8'h44, 1'b0}) begin
            failures++;
            $display("FAIL b2b_params got cur=%h thr=%h leak=%h ref=%h scale=%h fbd=%b want a5 11 22 3f 44 0",
                     bus.external_input_current, bus.threshold, bus.leak, bus.refractory_period,
                     bus.scale_factor, bus.feedback_delay);
        end
        repeat (2) step(1'b0, 8'h00);
        checks++;
        if (done_cnt !== 2 || err_cnt !== 0 || busy_cnt !== 14) begin
            failures++;
            $display("FAIL b2b_pulses got done=%0d err=%0d busy=%0d want 2 0 14", done_cnt, err_cnt, busy_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        step(1'b1, 8'hA5);
        step(1'b1, 8'h10);
        step(1'b1, 8'h40);
        step(1'b0, 8'h00);
        reset = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.params_valid !== 1'b0 || bus.threshold !== 8'd128
            || bus.external_input_current !== 8'd0 || bus.refractory_period !== 6'd4) begin
            failures++;
            $display("FAIL mid_reset got busy=%b pv=%b thr=%0d cur=%0d ref=%0d want 0 0 128 0 4",
                     bus.busy, bus.params_valid, bus.threshold, bus.external_input_current,
                     bus.refractory_period);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_counts();
        repeat (10) step(1'b0, 8'h00);
        checks++;
        if (done_cnt !== 0 || err_cnt !== 0 || busy_cnt !== 0) begin
            failures++;
            $display("FAIL mid_reset_pulses got done=%0d err=%0d busy=%0d want 0 0 0", done_cnt, err_cnt, busy_cnt);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clear_counts();
        test_reset();
        test_bad_checksum();
        test_good_frame();
        test_timeout();
        test_ignore_leading();
        test_back_to_back();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/neuron_param_loader.md
Name: neuron_param_loader

Overview:
Upstream configuration stage for the recursive spiking neuron. It deserialises a framed byte stream arriving on the 8-bit input pins into a shadow register bank and checks an XOR checksum. On a good checksum it atomically commits the bank to registered outputs that drive the neuron's parameter inputs: input current, threshold, leak, refractory period, scale factor and feedback delay. Malformed or stalled frames are rejected, and the previously committed parameters are kept.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker recognised in IDLE
TIMEOUT, 255, maximum idle cycles allowed between bytes inside a frame before abort (1..255)
RST_THRESHOLD, 8'd128, reset value of threshold
RST_LEAK, 8'd1, reset value of leak
RST_REFRAC, 6'd4, reset value of refractory_period
RST_SCALE, 8'd1, reset value of scale_factor

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
data_in  input  8  stream byte
data_valid  input  1  data_in is consumed on each rising edge where this is 1
external_input_current  output  8  committed input current to neuron
threshold  output  8  committed firing threshold
leak  output  8  committed leak value
refractory_period  output  6  committed refractory period
scale_factor  output  8  committed recurrent scale factor
feedback_delay  output  1  committed feedback delay select
params_valid  output  1  sticky; 1 after first successful commit
busy  output  1  1 while a frame is in progress
config_done  output  1  one-cycle pulse on successful commit
config_error  output  1  one-cycle pulse on checksum failure or timeout

Behaviour:
- Reset is asynchronous and active-high, with clock clk. All clocked state clears while reset=1.
- Reset values: external_input_current=0, threshold=RST_THRESHOLD, leak=RST_LEAK, refractory_period=RST_REFRAC, scale_factor=RST_SCALE, feedback_delay=0, params_valid=0, busy=0, config_done=0, config_error=0. FSM goes to IDLE; shadow registers, byte index and timeout counter go to 0.
- Frame format: SYNC_BYTE, then P0..P5, then CHK.
  - P0 = current, P1 = threshold, P2 = leak.
  - P3 = refractory period; bits[5:0] are stored, bits[7:6] are ignored.
  - P4 = scale factor.
  - P5 = feedback delay; bit0 is stored, bits[7:1] are ignored.
  - CHK = P0^P1^P2^P3^P4^P5, computed over full 8-bit bytes including the ignored bits.
- FSM states: IDLE, LOAD, CHECK.
  - IDLE: accepted byte == SYNC_BYTE moves to LOAD with index=0 and a running XOR of 0. Any other byte is ignored, with no error.
  - LOAD: each accepted byte goes to shadow[index], is XORed into the running checksum, and increments index. Acceptance at index 5 moves to CHECK. A SYNC_BYTE value in LOAD is plain data; there is no resync.
  - CHECK: the next accepted byte is compared with the running XOR, then the FSM returns to IDLE.
    - Match: on that same edge, all six outputs update from shadow, config_done=1 and params_valid=1.
    - Mismatch: on that edge config_error=1 and the outputs are unchanged.
- Latency: the new parameters and config_done are visible in the cycle immediately after the edge that accepts CHK. A minimum back-to-back frame is 8 consecutive valid cycles. A new SYNC may be accepted on the cycle right after CHK.
- busy=1 exactly while the state is LOAD or CHECK. It is registered, so it rises in the cycle after SYNC is accepted.
- Timeout:
  - In LOAD or CHECK, a counter increments on every cycle with data_valid=0 and clears on every accepted byte.
  - When the counter reaches TIMEOUT, the FSM goes to IDLE and config_error pulses for one cycle. Outputs are unchanged and the shadow registers are discarded.
  - The counter is held at 0 in IDLE.
- config_done and config_error are never high in the same cycle. Each is high for exactly one cycle per event.
- Committed outputs change only on a successful commit or on reset; they never show a partially loaded frame.
- Reset asserted mid-frame: the frame is abandoned, outputs return to their reset values, params_valid=0 and no pulse is generated.

Test Plan:
- Reset release, no stimulus -> threshold=128, leak=1, refractory_period=4, scale_factor=1, current=0, feedback_delay=0, params_valid=0, busy=0.
- Stream A5,10,40,02,05,03,01,55 on consecutive valid cycles -> next cycle: current=0x10, threshold=0x40, leak=0x02, refractory_period=5, scale_factor=3, feedback_delay=1, config_done=1 for one cycle, params_valid=1; busy high for exactly 7 cycles.
- Same frame with CHK=0x54 -> config_error one cycle, outputs stay at reset values, params_valid=0.
- Bytes 00,FF,A4 in IDLE, then a valid frame with P3=0xC5 and CHK=0x95 -> leading bytes ignored, refractory_period=5, commit succeeds.
- A5,10,40 then data_valid=0 for 255 cycles -> config_error pulses once; a following valid frame commits normally.
- Reset pulsed after A5,10,40 -> busy=0 immediately, outputs at reset values, no config_done or config_error pulse.
